multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Control FSM for the 8-bit multicycle processor. It sequences fetch, decode, execute and memory-access phases around the shared ALU, accumulator, PC and single-port memory.
- Drives ALUOp/Cin to the ALU, latches the ALU CZN flags into an architectural flag register, resolves conditional branches, and handshakes with memory using a timeout.

Parameters:
- OPW, 4, opcode width
- TIMEOUT, 15, max cycles mem_req may stay unacknowledged before fault (1..255)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin execution from IDLE
- opcode  input  OPW  IR opcode field (valid from DECODE onward)
- alu_czn  input  3  ALU {Cout,Zero,Negative}
- mem_ack  input  1  memory transfer complete this cycle
- mem_req  output  1  memory access request
- mem_we  output  1  write qualifier for mem_req
- addr_sel  output  1  0=PC, 1=IR operand
- ir_ld  output  1  load IR from memory data
- pc_inc  output  1  PC <= PC+1
- pc_ld  output  1  PC <= IR operand
- acc_ld  output  1  load accumulator
- acc_src  output  1  0=ALUout, 1=memory data
- alu_op  output  2  ALUOp: ADD=3, AND=1, OR=2
- alu_cin  output  1  ALU carry-in
- flags  output  3  registered {C,Z,N}
- busy  output  1  not in IDLE/HALT
- halted  output  1  in HALT
- fault  output  1  sticky: timeout or illegal opcode

Behaviour:
- Reset, asynchronous: state=IDLE, flags=0, fault=0, timer=0. Every output is 0 while rst_n=0 and in IDLE. Reset mid-transfer aborts immediately; no write completes.
- Opcodes: 0 NOP, 1 ADD, 2 ADC, 3 AND, 4 OR, 5 LDA, 6 STA, 7 JMP, 8 JZ, 9 JC, 10 JN, 11 HLT. Codes 12-15 are illegal.
- IDLE: start=1 moves to FETCH next edge. start is ignored in all other states.
- FETCH: mem_req=1, addr_sel=0.
  - On mem_ack, ir_ld=1 and pc_inc=1 combinationally in the same cycle, then go to DECODE.
- DECODE: one cycle, no memory activity.
  - ALU ops (1-4) go to EXEC.
  - LDA goes to MEM_RD; STA goes to MEM_WR.
  - NOP goes to FETCH.
  - JMP asserts pc_ld=1, then goes to FETCH.
  - JZ/JC/JN assert pc_ld=1 iff flags Z/C/N=1, then go to FETCH.
  - HLT goes to HALT.
  - Illegal opcodes set fault, then go to HALT.
- EXEC: one cycle.
  - alu_op: ADD/ADC give 3, AND gives 1, OR gives 2.
  - alu_cin = flags.C for ADC, otherwise 0.
  - acc_ld=1, acc_src=0.
  - flags <= alu_czn at the clock edge, then go to FETCH.
  - alu_op is 0 outside EXEC.
- MEM_RD: mem_req=1, addr_sel=1. On mem_ack, acc_ld=1 and acc_src=1, then go to FETCH. Flags unchanged.
- MEM_WR: mem_req=1, mem_we=1, addr_sel=1. On mem_ack, go to FETCH.
- Timeout (FETCH/MEM_RD/MEM_WR):
  - The timer clears on entry to each of these states and increments each cycle mem_req=1 without mem_ack.
  - If the timer reaches TIMEOUT with no ack, set fault and go to HALT. ack arriving on that same cycle wins.
- HALT: halted=1, all strobes 0. Exit only via rst_n.
- Instruction latency with zero-wait memory:
  - ALU ops: 3 cycles.
  - LDA/STA: 3 cycles.
  - Branches/NOP: 2 cycles.
- Flags change only in EXEC. LDA/STA/branches never modify flags.

Decomposition:
- Package multicycle_pkg holds:
  - opcode_t enum (values above) and state_t enum (IDLE, FETCH, DECODE, EXEC, MEM_RD, MEM_WR, HALT)
  - ALUOp localparams ALU_ADD=2'd3, ALU_AND=2'd1, ALU_OR=2'd2
  - CZN bit indices C=2, Z=1, N=0
- Sub-module mem_wait_timer (clear, count_en, ack, TIMEOUT) produces the expire signal.
- The FSM and flag register stay in multicycle_controller.

Test Plan:
- Reset then start, opcode=1 (ADD), ack immediate, alu_czn=3'b100 -> FETCH/DECODE/EXEC in 3 cycles; alu_op=3, alu_cin=0, acc_ld=1 in EXEC; flags=3'b100 after.
- Flags C=1, opcode=2 (ADC) -> alu_cin=1 in EXEC. Opcode=3 (AND) with alu_czn=3'b010 -> alu_op=1, flags=3'b010.
- Flags Z=1: JZ -> pc_ld=1 in DECODE. Flags Z=0: JZ -> pc_ld=0, next state FETCH, 2-cycle instruction.
- STA with mem_ack delayed 4 cycles -> mem_req=1 and mem_we=1 for 5 cycles, addr_sel=1, flags unchanged.
- FETCH with mem_ack never asserted, TIMEOUT=15 -> fault=1, halted=1 after 15 cycles; start then ignored.
- rst_n pulsed low mid-MEM_RD -> outputs 0 immediately, flags=0, state IDLE; opcode=13 after restart -> fault, HALT.

Source files
------------

// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multicycle processor control path.
package multicycle_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_ADD = 4'd1,
    OP_ADC = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_LDA = 4'd5,
    OP_STA = 4'd6,
    OP_JMP = 4'd7,
    OP_JZ  = 4'd8,
    OP_JC  = 4'd9,
    OP_JN  = 4'd10,
    OP_HLT = 4'd11
  } opcode_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM_RD = 3'd4,
    MEM_WR = 3'd5,
    HALT   = 3'd6
  } state_t;

  localparam logic [1:0] ALU_NONE = 2'd0;
  localparam logic [1:0] ALU_AND  = 2'd1;
  localparam logic [1:0] ALU_OR   = 2'd2;
  localparam logic [1:0] ALU_ADD  = 2'd3;

  localparam int FLAG_C = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts unacknowledged memory-request cycles and flags expiry on the last one.
module mem_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic count_en_i,
  input  logic ack_i,
  output logic expire_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_en_i && !ack_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // An ack in the final cycle suppresses expiry.
  assign expire_o = count_en_i && !ack_i && (cnt_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM sequencing fetch/decode/execute/memory phases with a flag register and memory timeout.
module multicycle_controller
  import multicycle_pkg::*;
#(
  parameter int OPW     = 4,
  parameter int TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [OPW-1:0] opcode,
  input  logic [2:0]     alu_czn,
  input  logic           mem_ack,
  output logic           mem_req,
  output logic           mem_we,
  output logic           addr_sel,
  output logic           ir_ld,
  output logic           pc_inc,
  output logic           pc_ld,
  output logic           acc_ld,
  output logic           acc_src,
  output logic [1:0]     alu_op,
  output logic           alu_cin,
  output logic [2:0]     flags,
  output logic           busy,
  output logic           halted,
  output logic           fault,
  output state_t         dbg_state
);

  state_t     state_q, state_d;
  logic [2:0] flags_q, flags_d;
  logic       fault_q, fault_d;
  logic       tmr_clear, tmr_count, expire;
  opcode_t    op;

  assign op = opcode_t'(opcode);

  // Memory handshake: mem_req holds until mem_ack; one ack completes one transfer.
  always_comb begin
    state_d  = state_q;
    flags_d  = flags_q;
    fault_d  = fault_q;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    addr_sel = 1'b0;
    ir_ld    = 1'b0;
    pc_inc   = 1'b0;
    pc_ld    = 1'b0;
    acc_ld   = 1'b0;
    acc_src  = 1'b0;
    alu_op   = ALU_NONE;
    alu_cin  = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = FETCH;
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_ld   = 1'b1;
          pc_inc  = 1'b1;
          state_d = DECODE;
        end else if (expire) begin
          fault_d = 1'b1;
          state_d = HALT;
        end
      end
      DECODE: begin
        case (op)
          OP_ADD, OP_ADC, OP_AND, OP_OR: state_d = EXEC;
          OP_LDA: state_d = MEM_RD;
          OP_STA: state_d = MEM_WR;
          OP_NOP: state_d = FETCH;
          OP_JMP: begin pc_ld = 1'b1;              state_d = FETCH; end
          OP_JZ:  begin pc_ld = flags_q[FLAG_Z];   state_d = FETCH; end
          OP_JC:  begin pc_ld = flags_q[FLAG_C];   state_d = FETCH; end
          OP_JN:  begin pc_ld = flags_q[FLAG_N];   state_d = FETCH; end
          OP_HLT: state_d = HALT;
          default: begin
            fault_d = 1'b1;
            state_d = HALT;
          end
        endcase
      end
      EXEC: begin
        acc_ld = 1'b1;
        case (op)
          OP_ADD: alu_op = ALU_ADD;
          OP_ADC: begin alu_op = ALU_ADD; alu_cin = flags_q[FLAG_C]; end
          OP_AND: alu_op = ALU_AND;
          OP_OR:  alu_op = ALU_OR;
          default: alu_op = ALU_NONE;
        endcase
        flags_d = alu_czn;
        state_d = FETCH;
      end
      MEM_RD: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        if (mem_ack) begin
          acc_ld  = 1'b1;
          acc_src = 1'b1;
          state_d = FETCH;
        end else if (expire) begin
          fault_d = 1'b1;
          state_d = HALT;
        end
      end
      MEM_WR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        addr_sel = 1'b1;
        if (mem_ack) begin
          state_d = FETCH;
        end else if (expire) begin
          fault_d = 1'b1;
          state_d = HALT;
        end
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // Any state change restarts the wait count, so each memory phase starts from zero.
  assign tmr_clear = (state_d != state_q);
  assign tmr_count = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (tmr_clear),
    .count_en_i(tmr_count),
    .ack_i     (mem_ack),
    .expire_o  (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      flags_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      fault_q <= fault_d;
    end
  end

  assign flags     = flags_q;
  assign fault     = fault_q;
  assign busy      = (state_q != IDLE) && (state_q != HALT);
  assign halted    = (state_q == HALT);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle expected output vectors checked by a monitor.
module tb_multicycle_controller;
  import multicycle_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] opcode;
  logic [2:0] alu_czn;
  logic       mem_ack;
  logic       mem_req, mem_we, addr_sel, ir_ld, pc_inc, pc_ld, acc_ld, acc_src;
  logic [1:0] alu_op;
  logic       alu_cin;
  logic [2:0] flags;
  logic       busy, halted, fault;
  state_t     dbg_state;

  logic [19:0] exp_q[$];
  string       tag_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [2:0]  fl;   // expected architectural flags
  logic        ft;   // expected sticky fault

  logic [19:0] act;
  assign act = {dbg_state, mem_req, mem_we, addr_sel, ir_ld, pc_inc, pc_ld, acc_ld, acc_src,
                alu_op, alu_cin, flags, busy, halted, fault};

  multicycle_controller #(.OPW(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .alu_czn(alu_czn),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
    .ir_ld(ir_ld), .pc_inc(pc_inc), .pc_ld(pc_ld), .acc_ld(acc_ld), .acc_src(acc_src),
    .alu_op(alu_op), .alu_cin(alu_cin), .flags(flags), .busy(busy), .halted(halted),
    .fault(fault), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver helpers ----------------
  function automatic logic [19:0] mk(input state_t s, input logic req, we, asel, irld, pcinc,
                                     pcld, accld, accsrc, input logic [1:0] aop, input logic cin);
    logic b, h;
    b = (s != IDLE) && (s != HALT);
    h = (s == HALT);
    return {s, req, we, asel, irld, pcinc, pcld, accld, accsrc, aop, cin, fl, b, h, ft};
  endfunction

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [19:0] v, input string t);
    exp_q.push_back(v);
    tag_q.push_back(t);
  endtask

  task automatic check(input string name, input logic [19:0] got, input logic [19:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", name, got, want);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("reset_outputs", act, 20'h0);
    fl = 3'b000;
    ft = 1'b0;
    adv();
    adv();
    rst_n = 1'b1;
  endtask

  task automatic go();
    start = 1'b1;
    adv();
    start = 1'b0;
  endtask

  task automatic fetch(input logic [3:0] op, input int w);
    opcode = op;
    for (int i = 0; i <= w; i++) begin
      mem_ack = (i == w);
      push(mk(FETCH, 1, 0, 0, mem_ack, mem_ack, 0, 0, 0, 2'd0, 0), "fetch");
      adv();
    end
    mem_ack = 1'b0;
  endtask

  task automatic instr(input logic [3:0] op, input int wf, input int wm, input logic [2:0] czn);
    logic taken;
    logic [1:0] aop;
    fetch(op, wf);
    case (op)
      4'd7:    taken = 1'b1;
      4'd8:    taken = fl[1];
      4'd9:    taken = fl[2];
      4'd10:   taken = fl[0];
      default: taken = 1'b0;
    endcase
    push(mk(DECODE, 0, 0, 0, 0, 0, taken, 0, 0, 2'd0, 0), "decode");
    adv();
    if (op >= 4'd12) ft = 1'b1;
    case (op)
      4'd1, 4'd2, 4'd3, 4'd4: begin
        case (op)
          4'd3:    aop = 2'd1;
          4'd4:    aop = 2'd2;
          default: aop = 2'd3;
        endcase
        alu_czn = czn;
        push(mk(EXEC, 0, 0, 0, 0, 0, 0, 1, 0, aop, (op == 4'd2) ? fl[2] : 1'b0), "exec");
        adv();
        fl = czn;
      end
      4'd5, 4'd6: begin
        for (int i = 0; i <= wm; i++) begin
          mem_ack = (i == wm);
          if (op == 4'd5)
            push(mk(MEM_RD, 1, 0, 1, 0, 0, 0, mem_ack, mem_ack, 2'd0, 0), "mem_rd");
          else
            push(mk(MEM_WR, 1, 1, 1, 0, 0, 0, 0, 0, 2'd0, 0), "mem_wr");
          adv();
        end
        mem_ack = 1'b0;
      end
      default: ;
    endcase
  endtask

  task automatic halt_hold(input int n);
    start = 1'b1;
    for (int i = 0; i < n; i++) begin
      push(mk(HALT, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0), "halt");
      adv();
    end
    start = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [19:0] e;
    string t;
    forever begin
      @(negedge clk);
      if (busy || halted || exp_q.size() != 0) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL extra_cycle got %h exp none", act);
        end else begin
          e = exp_q.pop_front();
          t = tag_q.pop_front();
          if (act !== e) begin
            n_errors++;
            $display("FAIL cycle_%s got %h exp %h", t, act, e);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; start = 1'b0; opcode = 4'd0; alu_czn = 3'b000; mem_ack = 1'b0;
    fl = 3'b000; ft = 1'b0;
    adv();
    do_reset();
    go();
    instr(4'd1, 0, 0, 3'b100);   // ADD
    instr(4'd2, 0, 0, 3'b100);   // ADC with C=1
    instr(4'd3, 0, 0, 3'b010);   // AND
    instr(4'd8, 0, 0, 3'b000);   // JZ taken
    instr(4'd9, 0, 0, 3'b000);   // JC not taken
    instr(4'd4, 0, 0, 3'b001);   // OR
    instr(4'd8, 0, 0, 3'b000);   // JZ not taken
    instr(4'd10, 0, 0, 3'b000);  // JN taken
    instr(4'd7, 0, 0, 3'b000);   // JMP
    instr(4'd0, 0, 0, 3'b000);   // NOP
    instr(4'd5, 2, 1, 3'b000);   // LDA, waited fetch and read
    instr(4'd6, 0, 4, 3'b000);   // STA, ack after 4 waits
    instr(4'd11, 0, 0, 3'b000);  // HLT
    halt_hold(2);
    do_reset();

    // fetch never acknowledged: 15 request cycles then fault
    go();
    opcode = 4'd1;
    for (int i = 0; i < 15; i++) begin
      push(mk(FETCH, 1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0), "timeout_fetch");
      adv();
    end
    ft = 1'b1;
    halt_hold(3);
    do_reset();

    // reset in the middle of a read
    go();
    instr(4'd1, 0, 0, 3'b111);
    fetch(4'd5, 0);
    push(mk(DECODE, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0), "decode");
    adv();
    push(mk(MEM_RD, 1, 0, 1, 0, 0, 0, 0, 0, 2'd0, 0), "mem_rd_wait");
    adv();
    do_reset();

    // illegal opcode
    go();
    instr(4'd13, 0, 0, 3'b000);
    halt_hold(2);
    do_reset();

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL leftover_expect got %0d exp 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
